// File: rtl/block_interleaver.sv
// -----------------------------------------------------------------------------
// block_interleaver
//
// 802.11a transmit bit interleaver. Applies both standard permutations for
// every modulation. Bits are written into a ping-pong pair of banks at their
// permuted address and then read out of the other bank in natural order, so
// the block sustains one bit per clock.
//
// Each bank keeps its own latched mode (and Deint flag) and a full flag.
// A bank is filled only while it is not full and drained only while it is
// full, so the fill bank and the drain bank are never the same bank.
//
// Ports
//   Clock      rising-edge clock
//   Reset      asynchronous, active-high reset
//   Mode       modulation (0 BPSK, 1 QPSK, 2 16-QAM, 3 64-QAM), sampled
//              with the first bit of each symbol
//   Deint      (BLOCK_INTERLEAVER_DEINT_EN only) 1 = inverse permutation,
//              sampled with the first bit of each symbol
//   In_Data    coded input bit
//   In_Valid   In_Data valid
//   In_Ready   block accepts a bit this cycle
//   Out_Data   interleaved output bit (registered)
//   Out_Valid  Out_Data valid (registered)
//   Out_Ready  downstream accepts Out_Data
//
// Build option
//   BLOCK_INTERLEAVER_DEINT_EN  adds the Deint input and the inverse
//                               (receive-side) address generator.
// -----------------------------------------------------------------------------
module block_interleaver #(
    parameter int N_CBPS_MAX = 288,
    parameter int N_COLS     = 16
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [1:0] Mode,
`ifdef BLOCK_INTERLEAVER_DEINT_EN
    input  logic       Deint,
`endif
    input  logic       In_Data,
    input  logic       In_Valid,
    output logic       In_Ready,
    output logic       Out_Data,
    output logic       Out_Valid,
    input  logic       Out_Ready
);

    localparam int AW = $clog2(N_CBPS_MAX);
    localparam int CW = $clog2(N_COLS);

    function automatic logic [AW-1:0] ncbps_f(input logic [1:0] m);
        case (m)
            2'd0:    ncbps_f = AW'(48);
            2'd1:    ncbps_f = AW'(96);
            2'd2:    ncbps_f = AW'(192);
            default: ncbps_f = AW'(288);
        endcase
    endfunction

    // Rows of the interleaver matrix: N_CBPS / 16.
    function automatic logic [AW-1:0] rows_f(input logic [1:0] m);
        case (m)
            2'd0:    rows_f = AW'(3);
            2'd1:    rows_f = AW'(6);
            2'd2:    rows_f = AW'(12);
            default: rows_f = AW'(18);
        endcase
    endfunction

    // s = max(N_BPSC/2, 1)
    function automatic logic [1:0] s_f(input logic [1:0] m);
        case (m)
            2'd0:    s_f = 2'd1;
            2'd1:    s_f = 2'd1;
            2'd2:    s_f = 2'd2;
            default: s_f = 2'd3;
        endcase
    endfunction

    function automatic logic [1:0] mod_inc(input logic [1:0] v, input logic [1:0] s);
        mod_inc = (v == s - 2'd1) ? 2'd0 : v + 2'd1;
    endfunction

    // ---------------------------------------------------------------- state
    logic                  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]         col_q, col_d;
    logic [AW-1:0]         row_q, row_d;
    logic [AW-1:0]         i_q, i_d;
    logic [1:0]            rmod_q, rmod_d;
    logic [1:0]            cmod_q, cmod_d;
    logic [1:0]            full_q, full_d;
    logic [1:0][1:0]       mode_q, mode_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]         rd_cnt_q, rd_cnt_d;
    logic                  out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic [N_CBPS_MAX-1:0] mem_q [2];

    // ------------------------------------------------------- write address
    logic [1:0]    wr_mode;
    logic [AW-1:0] wr_n, wr_rows, wr_addr, fwd_addr;
    logic [1:0]    wr_s;
    logic [2:0]    fwd_rot;
    logic          accept, wr_last;

    assign wr_mode = (wr_cnt_q == '0) ? Mode : mode_q[wr_ptr_q];
    assign wr_n    = ncbps_f(wr_mode);
    assign wr_rows = rows_f(wr_mode);
    assign wr_s    = s_f(wr_mode);
    assign accept  = In_Valid && In_Ready;
    assign wr_last = (wr_cnt_q == wr_n - AW'(1));

    // With i = rows*col + row and rows a multiple of s, i mod s == row mod s
    // and floor(16*i/N_CBPS) == col, so the rotation term reduces to
    // (row - col) mod s, tracked with two small mod-s counters.
    assign fwd_rot  = (rmod_q >= cmod_q) ? ({1'b0, rmod_q} - {1'b0, cmod_q})
                                         : ({1'b0, rmod_q} + {1'b0, wr_s} - {1'b0, cmod_q});
    assign fwd_addr = i_q - AW'(rmod_q) + AW'(fwd_rot[1:0]);

`ifdef BLOCK_INTERLEAVER_DEINT_EN
    logic [1:0]    deint_q, deint_d;
    logic [AW-1:0] dr_q, dr_d;
    logic [CW-1:0] dq_q, dq_d;
    logic [1:0]    dm_q, dm_d;
    logic [1:0]    dqm_q, dqm_d;
    logic          wr_deint;
    logic [2:0]    inv_sum, inv_rot;
    logic [AW-1:0] inv_addr;

    // Inverse path: j = rows*dq + dr. The s-group of j never crosses a row
    // boundary, so k = 16*(dr - j mod s + (j mod s + dq) mod s) + dq.
    assign wr_deint = (wr_cnt_q == '0) ? Deint : deint_q[wr_ptr_q];
    assign inv_sum  = {1'b0, dm_q} + {1'b0, dqm_q};
    assign inv_rot  = (inv_sum >= {1'b0, wr_s}) ? inv_sum - {1'b0, wr_s} : inv_sum;
    assign inv_addr = AW'(N_COLS) * (dr_q - AW'(dm_q) + AW'(inv_rot[1:0])) + AW'(dq_q);
    assign wr_addr  = wr_deint ? inv_addr : fwd_addr;
`else
    assign wr_addr  = fwd_addr;
`endif

    // ---------------------------------------------------------- read side
    logic          load, avail, rd_last;

    assign load    = !out_valid_q || Out_Ready;
    assign avail   = full_q[rd_ptr_q];
    assign rd_last = (rd_cnt_q == ncbps_f(mode_q[rd_ptr_q]) - AW'(1));

    // ------------------------------------------------------ next state
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        wr_cnt_d    = wr_cnt_q;
        col_d       = col_q;
        row_d       = row_q;
        i_d         = i_q;
        rmod_d      = rmod_q;
        cmod_d      = cmod_q;
        full_d      = full_q;
        mode_d      = mode_q;
        rd_ptr_d    = rd_ptr_q;
        rd_cnt_d    = rd_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
`ifdef BLOCK_INTERLEAVER_DEINT_EN
        deint_d     = deint_q;
        dr_d        = dr_q;
        dq_d        = dq_q;
        dm_d        = dm_q;
        dqm_d       = dqm_q;
`endif

        if (accept) begin
            if (wr_cnt_q == '0) begin
                mode_d[wr_ptr_q]  = Mode;
`ifdef BLOCK_INTERLEAVER_DEINT_EN
                deint_d[wr_ptr_q] = Deint;
`endif
            end
            if (wr_last) begin
                full_d[wr_ptr_q] = 1'b1;
                wr_ptr_d         = ~wr_ptr_q;
                wr_cnt_d         = '0;
                col_d            = '0;
                row_d            = '0;
                i_d              = '0;
                rmod_d           = '0;
                cmod_d           = '0;
`ifdef BLOCK_INTERLEAVER_DEINT_EN
                dr_d             = '0;
                dq_d             = '0;
                dm_d             = '0;
                dqm_d            = '0;
`endif
            end else begin
                wr_cnt_d = wr_cnt_q + AW'(1);
                if (col_q == CW'(N_COLS - 1)) begin
                    col_d  = '0;
                    cmod_d = '0;
                    row_d  = row_q + AW'(1);
                    rmod_d = mod_inc(rmod_q, wr_s);
                    i_d    = row_q + AW'(1);
                end else begin
                    col_d  = col_q + CW'(1);
                    cmod_d = mod_inc(cmod_q, wr_s);
                    i_d    = i_q + wr_rows;
                end
`ifdef BLOCK_INTERLEAVER_DEINT_EN
                if (dr_q == wr_rows - AW'(1)) begin
                    dr_d  = '0;
                    dm_d  = '0;
                    dq_d  = dq_q + CW'(1);
                    dqm_d = mod_inc(dqm_q, wr_s);
                end else begin
                    dr_d  = dr_q + AW'(1);
                    dm_d  = mod_inc(dm_q, wr_s);
                end
`endif
            end
        end

        if (load) begin
            if (avail) begin
                out_data_d  = mem_q[rd_ptr_q][rd_cnt_q];
                out_valid_d = 1'b1;
                if (rd_last) begin
                    full_d[rd_ptr_q] = 1'b0;
                    rd_ptr_d         = ~rd_ptr_q;
                    rd_cnt_d         = '0;
                end else begin
                    rd_cnt_d = rd_cnt_q + AW'(1);
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q    <= 1'b0;
            wr_cnt_q    <= '0;
            col_q       <= '0;
            row_q       <= '0;
            i_q         <= '0;
            rmod_q      <= '0;
            cmod_q      <= '0;
            full_q      <= '0;
            mode_q      <= '0;
            rd_ptr_q    <= 1'b0;
            rd_cnt_q    <= '0;
            out_data_q  <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef BLOCK_INTERLEAVER_DEINT_EN
            deint_q     <= '0;
            dr_q        <= '0;
            dq_q        <= '0;
            dm_q        <= '0;
            dqm_q       <= '0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            wr_cnt_q    <= wr_cnt_d;
            col_q       <= col_d;
            row_q       <= row_d;
            i_q         <= i_d;
            rmod_q      <= rmod_d;
            cmod_q      <= cmod_d;
            full_q      <= full_d;
            mode_q      <= mode_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_cnt_q    <= rd_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
`ifdef BLOCK_INTERLEAVER_DEINT_EN
            deint_q     <= deint_d;
            dr_q        <= dr_d;
            dq_q        <= dq_d;
            dm_q        <= dm_d;
            dqm_q       <= dqm_d;
`endif
        end
    end

    // Bank storage is not reset: every location is rewritten before it is read.
    always_ff @(posedge Clock) begin
        if (accept) begin
            mem_q[wr_ptr_q][wr_addr] <= In_Data;
        end
    end

    assign In_Ready  = !full_q[wr_ptr_q];
    assign Out_Data  = out_data_q;
    assign Out_Valid = out_valid_q;

endmodule

// File: tb/tb_block_interleaver.sv
module tb_block_interleaver;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [1:0] Mode;
    logic       In_Data, In_Valid, In_Ready;
    logic       Out_Data, Out_Valid, Out_Ready;
`ifdef BLOCK_INTERLEAVER_DEINT_EN
    logic       Deint;
    bit         d_q[$];
`endif

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_acc_cyc = -1;
    int         first_valid_cyc = -1;
    bit         in_q[$];
    logic [1:0] m_q[$];
    bit         out_q[$];
    bit         exp_q[$];
    int         out_cyc[$];
    bit         sym[288];

    block_interleaver dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Mode     (Mode),
`ifdef BLOCK_INTERLEAVER_DEINT_EN
        .Deint    (Deint),
`endif
        .In_Data  (In_Data),
        .In_Valid (In_Valid),
        .In_Ready (In_Ready),
        .Out_Data (Out_Data),
        .Out_Valid(Out_Valid),
        .Out_Ready(Out_Ready)
    );

    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic int ncb(int m);
        case (m)
            0: return 48;
            1: return 96;
            2: return 192;
            default: return 288;
        endcase
    endfunction

    function automatic int bpsc(int m);
        case (m)
            0: return 1;
            1: return 2;
            2: return 4;
            default: return 6;
        endcase
    endfunction

    // Reference permutation written straight from the standard formulas.
    function automatic int jf(int m, int k);
        int n, s, i;
        n = ncb(m);
        s = bpsc(m) / 2;
        if (s < 1) s = 1;
        i = (n / 16) * (k % 16) + k / 16;
        return s * (i / s) + (i + n - (16 * i) / n) % s;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic step(output bit acc);
        bit ox, od;
        acc = (In_Valid === 1'b1) && (In_Ready === 1'b1);
        ox  = (Out_Valid === 1'b1) && (Out_Ready === 1'b1);
        od  = Out_Data;
        @(posedge Clock);
        #1;
        cyc++;
        if (acc) last_acc_cyc = cyc;
        if (ox) begin
            out_q.push_back(od);
            out_cyc.push_back(cyc);
        end
        if (Out_Valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
    endtask

    task automatic idle(int n);
        bit acc;
        In_Valid = 1'b0;
        repeat (n) step(acc);
    endtask

    task automatic run_io(int n_out, int budget, string tag);
        bit acc;
        int b = 0;
        while ((in_q.size() > 0 || out_q.size() < n_out) && b < budget) begin
            if (in_q.size() > 0) begin
                In_Valid = 1'b1;
                In_Data  = in_q[0];
                Mode     = m_q[0];
`ifdef BLOCK_INTERLEAVER_DEINT_EN
                Deint    = d_q[0];
`endif
            end else begin
                In_Valid = 1'b0;
            end
            step(acc);
            if (acc) begin
                void'(in_q.pop_front());
                void'(m_q.pop_front());
`ifdef BLOCK_INTERLEAVER_DEINT_EN
                void'(d_q.pop_front());
`endif
            end
            b++;
        end
        In_Valid = 1'b0;
        chk({tag, "_in_left"}, in_q.size(), 0);
    endtask

    task automatic rand_sym();
        foreach (sym[i]) sym[i] = 1'($urandom_range(0, 1));
    endtask

    // Queues one symbol; Mode is only meaningful at k=0, so the other
    // cycles carry random modes that the block must ignore.
    task automatic push_sym(int m);
        bit e[288];
        int n = ncb(m);
        for (int k = 0; k < n; k++) begin
            in_q.push_back(sym[k]);
            m_q.push_back((k == 0) ? 2'(m) : 2'($urandom_range(0, 3)));
`ifdef BLOCK_INTERLEAVER_DEINT_EN
            d_q.push_back(1'b0);
`endif
            e[jf(m, k)] = sym[k];
        end
        for (int k = 0; k < n; k++) exp_q.push_back(e[k]);
    endtask

    task automatic cmp_out(string tag);
        int mism = 0;
        int n;
        chk({tag, "_len"}, out_q.size(), exp_q.size());
        n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (out_q[i] !== exp_q[i]) mism++;
        chk({tag, "_bits"}, mism, 0);
        out_q.delete();
        exp_q.delete();
        out_cyc.delete();
    endtask

    task automatic onehot(int m, int k, int idx, string tag);
        int ones = 0;
        int pos = -1;
        foreach (sym[i]) sym[i] = 1'b0;
        sym[k] = 1'b1;
        push_sym(m);
        exp_q.delete();
        run_io(ncb(m), 2000, tag);
        foreach (out_q[i]) if (out_q[i]) begin
            ones++;
            pos = i;
        end
        chk({tag, "_pos"}, pos, idx);
        chk({tag, "_ones"}, ones, 1);
        out_q.delete();
        out_cyc.delete();
    endtask

    initial begin
        bit first_bit;
        bit orig[288];
        bit y[$];

        Reset     = 1'b1;
        Mode      = 2'd0;
        In_Data   = 1'b0;
        In_Valid  = 1'b0;
        Out_Ready = 1'b1;
`ifdef BLOCK_INTERLEAVER_DEINT_EN
        Deint     = 1'b0;
`endif
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
        idle(1);
        chk("rst_out_valid", Out_Valid, 0);
        chk("rst_out_data", Out_Data, 0);
        chk("rst_in_ready", In_Ready, 1);

        // Single-bit probes with hand-derived positions.
        first_valid_cyc = -1;
        onehot(0, 1, 3, "bpsk_k1");
        chk("bpsk_latency", first_valid_cyc - last_acc_cyc, 1);
        onehot(0, 16, 1, "bpsk_k16");
        onehot(1, 1, 6, "qpsk_k1");
        onehot(2, 1, 13, "qam16_k1");
        onehot(2, 0, 0, "qam16_k0");
        onehot(3, 1, 20, "qam64_k1");

        // Back-to-back mixed-mode stream, both sides always ready.
        rand_sym(); push_sym(3);
        rand_sym(); push_sym(0);
        rand_sym(); push_sym(2);
        rand_sym(); push_sym(1);
        run_io(624, 4000, "stream");
        chk("stream_no_gap", (out_cyc.size() >= 336) ? out_cyc[335] - out_cyc[0] : -1, 335);
        cmp_out("stream");

        // Downstream stalled: both banks fill, then the output must freeze.
        Out_Ready = 1'b0;
        rand_sym();
        first_bit = sym[0];
        push_sym(0);
        rand_sym();
        push_sym(0);
        run_io(0, 400, "bp_fill");
        chk("bp_in_ready_low", In_Ready, 0);
        chk("bp_out_valid", Out_Valid, 1);
        chk("bp_out_data", Out_Data, first_bit);
        idle(20);
        chk("bp_out_hold", Out_Data, first_bit);
        chk("bp_in_ready_hold", In_Ready, 0);
        Out_Ready = 1'b1;
        run_io(96, 400, "bp_drain");
        cmp_out("bp");

        // Reset in the middle of a 16-QAM symbol.
        for (int k = 0; k < 100; k++) begin
            in_q.push_back(1'($urandom_range(0, 1)));
            m_q.push_back(2'd2);
`ifdef BLOCK_INTERLEAVER_DEINT_EN
            d_q.push_back(1'b0);
`endif
        end
        run_io(0, 400, "mid_fill");
        Reset = 1'b1;
        idle(2);
        Reset = 1'b0;
        idle(1);
        chk("mid_rst_out_valid", Out_Valid, 0);
        chk("mid_rst_out_data", Out_Data, 0);
        chk("mid_rst_in_ready", In_Ready, 1);
        out_q.delete();
        out_cyc.delete();
        rand_sym();
        push_sym(0);
        run_io(48, 400, "post_rst");
        cmp_out("post_rst");

`ifdef BLOCK_INTERLEAVER_DEINT_EN
        // Interleave a 64-QAM symbol, then feed it back through the inverse.
        rand_sym();
        foreach (orig[i]) orig[i] = sym[i];
        push_sym(3);
        run_io(288, 1000, "fwd64");
        foreach (out_q[i]) y.push_back(out_q[i]);
        out_q.delete();
        exp_q.delete();
        out_cyc.delete();
        for (int k = 0; k < 288; k++) begin
            in_q.push_back((k < y.size()) ? y[k] : 1'b0);
            m_q.push_back((k == 0) ? 2'd3 : 2'($urandom_range(0, 3)));
            d_q.push_back(k == 0);
            exp_q.push_back(orig[k]);
        end
        run_io(288, 1000, "inv64");
        cmp_out("deint_roundtrip");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/block_interleaver.md
# block_interleaver

Parametrised, rate-adaptive 802.11a bit interleaver for the transmit PLCP DATA path, between the convolutional encoder/puncturer and the constellation mapper. Applies both standard permutations (adjacent-bit column spread, then constellation-bit rotation) for every 802.11a modulation. Uses a ping-pong bit buffer with valid/ready handshakes on both sides to sustain one bit per clock.

## Interface
- `N_CBPS_MAX`, default 288: bits per bank; must be ≥ the largest N_CBPS used.
- `N_COLS`, default 16: interleaver column count; fixed by standard.
- `Clock` in 1: rising-edge clock.
- `Reset` in 1: reset, asynchronous, active-high.
- `Mode` in 2: modulation of symbol; sampled with the first bit of each symbol. Values:
  - 0: BPSK, N_CBPS 48, N_BPSC 1.
  - 1: QPSK, N_CBPS 96, N_BPSC 2.
  - 2: 16-QAM, N_CBPS 192, N_BPSC 4.
  - 3: 64-QAM, N_CBPS 288, N_BPSC 6.
- `In_Data` in 1: coded bit.
- `In_Valid` in 1: `In_Data` valid.
- `In_Ready` out 1: block accepts a bit this cycle.
- `Out_Data` out 1: interleaved bit.
- `Out_Valid` out 1: `Out_Data` valid.
- `Out_Ready` in 1: downstream accepts `Out_Data`.

## Operation
- Two banks A/B of `N_CBPS_MAX` bits. Each bank holds its own latched mode, fill count and a full flag.
- The write pointer selects the fill bank and starts at A; the read pointer selects the drain bank and starts at A.
- Input bit k (0..N_CBPS−1) is written to address j(k):
  - i = (N_CBPS/16)·(k mod 16) + ⌊k/16⌋
  - s = max(N_BPSC/2, 1)
  - j = s·⌊i/s⌋ + (i + N_CBPS − ⌊16·i/N_CBPS⌋) mod s
- Address generation uses row/column counters and a mod-s counter, not a divider.
- Input accept occurs when `In_Valid` and `In_Ready` are both high.
- At k = 0 of a symbol, `Mode` (and `Deint`, if compiled in) is latched into the fill bank.
- When the last bit (k = N_CBPS−1) is accepted:
  - the bank's full flag sets;
  - the write pointer toggles.
- `In_Ready` = !full of the current fill bank.
- Drain reads the drain bank sequentially, addresses 0..N_CBPS−1, using that bank's latched N_CBPS.
- After the last output transfer from a bank:
  - the bank's full flag clears;
  - the read pointer toggles.
- Mode changes mid-symbol are ignored; the latched mode governs the whole symbol.
- Partial symbols are held indefinitely. No timeout, no padding.
- Reset behaviour, mid-operation included:
  - all full flags, counters and pointers clear;
  - partial and buffered symbols are discarded;
  - `Out_Data`=0, `Out_Valid`=0, `In_Ready`=1 on the next edge after reset release.
  - Bank contents are not cleared; they are never read before being rewritten.

## Timing
- `Out_Data`/`Out_Valid` are registered.
- `Out_Valid` rises one cycle after the edge that accepts the last input bit of a symbol.
- Output register load: on any cycle where `Out_Valid`=0 or `Out_Ready`=1, the register loads the next bit if one is available, else `Out_Valid` drops to 0.
- `Out_Data` must remain stable while `Out_Valid`=1 and `Out_Ready`=0.
- Throughput with `In_Valid` and `Out_Ready` held high is 1 bit/cycle in steady state, with no bubbles between symbols.
- `In_Ready` falls on the edge after both banks become full. It rises one cycle after the drain bank empties.
- Simultaneous fill-complete of bank X and drain-complete of bank Y in the same cycle: both flags update in that cycle, with no lost or duplicated bit.
- Mixed-mode back-to-back symbols each drain with their own length.

## Configuration
- `BLOCK_INTERLEAVER_DEINT_EN` defined:
  - adds input `Deint` (1 bit), latched per symbol with `Mode`;
  - `Deint`=1 applies the inverse mapping: input bit j is written to address k(j), where
    - i = s·⌊j/s⌋ + (j + ⌊16·j/N_CBPS⌋) mod s
    - k = 16·i − (N_CBPS−1)·⌊16·i/N_CBPS⌋
  - `Deint`=1 lets the receive path reuse the block; `Deint`=0 interleaves.
- Macro undefined: `Deint` port absent; forward interleave only.

## Test plan
- BPSK, one-hot input at k=1 (48 bits) -> output one-hot at index 3. One-hot at k=16 -> output index 1. First `Out_Valid` exactly one cycle after the 48th accept.
- QPSK, one-hot at k=1 -> output index 6. 16-QAM, one-hot at k=1 -> output index 13; k=0 -> index 0. 64-QAM, one-hot at k=1 -> output index 20.
- Continuous stream of 4 symbols (64-QAM, BPSK, 16-QAM, QPSK), both sides always ready -> 624 output bits with no idle cycles after the first symbol; each symbol matches the golden model.
- `Out_Ready` held 0 -> `In_Ready` falls after 96 accepted BPSK bits; `Out_Data` stays frozen. Release -> drain resumes with no loss.
- Assert `Reset` after 100 bits of a 192-bit symbol -> outputs 0/0, `In_Ready`=1. A fresh BPSK symbol then interleaves correctly.
- With `BLOCK_INTERLEAVER_DEINT_EN` defined: 64-QAM random symbol interleaved, then fed back with `Deint`=1 -> the original bit sequence is restored.
